// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Optional two's-complement input with sign flag when SIGNED_EN is defined; otherwise neg is tied 0.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  neg
);

  localparam int SCR_DIGITS = 10;
  localparam int SCR_W      = 4 * SCR_DIGITS;
  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      shreg_q, shreg_d;
  logic [SCR_W-1:0]      scratch_q, scratch_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [WIDTH-1:0]      load_val;
  logic [SCR_W-1:0]      scratch_adj;
  logic                  ovf_hi;

  // Every digit is <=9 here, so the +3 correction can never carry out of its nibble.
  function automatic logic [SCR_W-1:0] add3_digits(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int i = 0; i < SCR_DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    scratch_adj = add3_digits(scratch_q);
  end

  always_comb begin
    ovf_hi = 1'b0;
    for (int i = DIGITS; i < SCR_DIGITS; i++) begin
      ovf_hi = ovf_hi | (|scratch_q[4*i +: 4]);
    end
  end

`ifdef SIGNED_EN
  logic neg_pend_q, neg_pend_d;
  logic neg_q, neg_d;

  // Negating the most negative value yields its correct unsigned magnitude.
  always_comb begin
    load_val = bin[WIDTH-1] ? ((~bin) + WIDTH'(1)) : bin;
  end
`else
  always_comb begin
    load_val = bin;
  end
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
`ifdef SIGNED_EN
    neg_pend_d = neg_pend_q;
    neg_d      = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d   = load_val;
          scratch_d = '0;
          cnt_d     = '0;
`ifdef SIGNED_EN
          neg_pend_d = bin[WIDTH-1];
`endif
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = {scratch_adj[SCR_W-2:0], shreg_q[WIDTH-1]};
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d   = scratch_q[4*DIGITS-1:0];
        ovf_d   = ovf_hi;
        done_d  = 1'b1;
`ifdef SIGNED_EN
        neg_d   = neg_pend_q;
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

`ifdef SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      neg_pend_q <= neg_pend_d;
      neg_q      <= neg_d;
    end
  end

  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: queued expected results from a decimal model, compared on each done pulse.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;
  logic        neg;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf),
    .neg   (neg)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [33:0] sb_q[$];
  logic [33:0] sb_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {neg, ovf, bcd} by repeated division.
  function automatic logic [33:0] model(input logic [31:0] b);
    longint unsigned v;
    logic [31:0]     r;
    logic            sgn;
    v   = 64'(b);
    sgn = 1'b0;
    r   = '0;
`ifdef SIGNED_EN
    if (b[31]) begin
      sgn = 1'b1;
      v   = 64'd4294967296 - 64'(b);
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {sgn, (v != 0), r};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'(done), 64'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check_eq("bcd", 64'(bcd), 64'(sb_e[31:0]));
        check_eq("ovf", 64'(ovf), 64'(sb_e[32]));
        check_eq("neg", 64'(neg), 64'(sb_e[33]));
      end
    end
  end

  task automatic accept(input logic [31:0] b, output int t0);
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    bin   = $urandom;
    sb_q.push_back(model(b));
  endtask

  task automatic wait_done(input string tag, output int stamp, output int busy_n);
    stamp  = -1;
    busy_n = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) begin
        stamp = cyc;
        break;
      end
      if (busy) busy_n++;
    end
    if (stamp < 0) check_eq({tag, "_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic convert(input logic [31:0] b, input string tag);
    int t0, t1, bn;
    accept(b, t0);
    wait_done(tag, t1, bn);
    check_eq({tag, "_latency"}, 64'(t1 - t0), 64'd33);
    check_eq({tag, "_busy_cycles"}, 64'(bn), 64'd33);
    check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  int t0, t1, t2, bn;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_bcd",  64'(bcd),  64'd0);
    check_eq("rst_ovf",  64'(ovf),  64'd0);
    check_eq("rst_neg",  64'(neg),  64'd0);
    rst_n = 1'b1;

    convert(32'd0,          "zero");
    convert(32'd12345678,   "mid");
    convert(32'd99999999,   "max8");
    convert(32'd100000000,  "ovf9");
    convert(32'hFFFF_FFFF,  "allones");
    convert(32'h8000_0000,  "msb");
    convert(32'd7,          "seven");

    repeat (5) @(negedge clk);
    check_eq("hold_bcd", 64'(bcd), 64'(model(32'd7) & 34'h0_FFFF_FFFF));

    // Starts while busy must be ignored; start in the done cycle is accepted.
    accept(32'd55555555, t0);
    t1 = -1;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        t1 = cyc;
        break;
      end
      if (k == 5 || k == 20) begin
        start = 1'b1;
        bin   = 32'd11111111;
      end else begin
        start = 1'b0;
      end
    end
    if (t1 < 0) check_eq("ignore_timeout", 64'(done), 64'd1);
    check_eq("ignore_latency", 64'(t1 - t0), 64'd33);
    start = 1'b1;
    bin   = 32'd24680;
    sb_q.push_back(model(32'd24680));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("b2b", t2, bn);
    check_eq("b2b_gap", 64'(t2 - t1), 64'd34);

    // Reset mid-conversion discards the result with no done.
    accept(32'd87654321, t0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_bcd",  64'(bcd),  64'd0);
    check_eq("abort_ovf",  64'(ovf),  64'd0);
    void'(sb_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("abort_idle_bcd", 64'(bcd), 64'd0);
    convert(32'd42, "after_abort");

    for (int i = 0; i < 6; i++) begin
      convert($urandom, "rand");
    end

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
